// File: rtl/waveform_sequencer.sv
// Sample-rate controller for the counter-based waveform generator.
// Ticks at a programmable rate and requests one sample per tick. It waits for
// the selected generator output, applies an optional linear phase sweep, and
// raises sticky timeout/overrun flags when a response or a tick is lost.
module waveform_sequencer #(
  parameter int N_FRAC  = 7,
  parameter int DIV_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              clear_flags_i,
  input  logic [1:0]        wave_sel_i,
  input  logic [DIV_W-1:0]  sample_div_i,
  input  logic [N_FRAC:0]   phase_start_i,
  input  logic [N_FRAC:0]   phase_step_i,
  input  logic [N_FRAC:0]   phase_stop_i,
  input  logic              sweep_en_i,
  input  logic [7:0]        samples_per_step_i,
  input  logic [N_FRAC:0]   saw_i,
  input  logic              saw_valid_i,
  input  logic [N_FRAC:0]   tri_i,
  input  logic              tri_valid_i,
  input  logic [N_FRAC:0]   sq_i,
  input  logic              sq_valid_i,
  output logic [N_FRAC:0]   phase_o,
  output logic              next_data_strobe_o,
  output logic [N_FRAC:0]   data_o,
  output logic              data_valid_strobe_o,
  output logic              busy_o,
  output logic              timeout_o,
  output logic              overrun_o
);
  localparam int W  = N_FRAC + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       sel_q, sel_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [7:0]       swp_cnt_q, swp_cnt_d;
  logic [W-1:0]     phase_q, phase_d;
  logic [W-1:0]     data_q, data_d;
  logic             req_q, req_d;
  logic             dvs_q, dvs_d;
  logic             timeout_q, timeout_d;
  logic             overrun_q, overrun_d;

  logic             tick;
  logic             sel_vld;
  logic [W-1:0]     sel_smp;
  logic signed [W:0] sum_x, stop_x;
  logic             step_pos, step_zero, sum_ovf, past_stop, swp_act, step_due;
  logic             to_set, ov_set;

  // Sample-rate divider: counts 0..sample_div_i, ticks on the last count
  always_comb begin
    tick  = enable_i && (div_q == sample_div_i);
    div_d = (!enable_i || tick) ? '0 : div_q + 1'b1;
  end

  // Route the latched waveform's strobe/sample; mute rides on the saw strobe
  always_comb begin
    sel_vld = saw_valid_i;
    sel_smp = '0;
    case (sel_q)
      2'd0: begin sel_vld = saw_valid_i; sel_smp = saw_i; end
      2'd1: begin sel_vld = tri_valid_i; sel_smp = tri_i; end
      2'd2: begin sel_vld = sq_valid_i;  sel_smp = sq_i;  end
      default: begin sel_vld = saw_valid_i; sel_smp = '0; end
    endcase
  end

  // Sweep arithmetic: one extra bit to catch leaving the signed sample range
  always_comb begin
    sum_x     = $signed({phase_q[W-1], phase_q}) + $signed({phase_step_i[W-1], phase_step_i});
    stop_x    = $signed({phase_stop_i[W-1], phase_stop_i});
    step_zero = (phase_step_i == '0);
    step_pos  = !phase_step_i[W-1] && !step_zero;
    sum_ovf   = sum_x[W] ^ sum_x[W-1];
    past_stop = step_pos ? (sum_x > stop_x) : (sum_x < stop_x);
    swp_act   = sweep_en_i && (samples_per_step_i != 8'd0);
    step_due  = swp_act && (swp_cnt_q >= samples_per_step_i);
  end

  // Request/response FSM, phase update and flag set conditions
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    tmo_d     = tmo_q;
    swp_cnt_d = swp_cnt_q;
    phase_d   = phase_q;
    data_d    = data_q;
    req_d     = 1'b0;
    dvs_d     = 1'b0;
    to_set    = 1'b0;
    ov_set    = 1'b0;
    case (state_q)
      IDLE: begin
        // phase only moves here so it stays constant across a request
        if (!enable_i) begin
          phase_d   = phase_start_i;
          swp_cnt_d = '0;
        end else if (step_due) begin
          swp_cnt_d = '0;
          if (!step_zero)
            phase_d = (sum_ovf || past_stop) ? phase_start_i : sum_x[W-1:0];
        end
        if (tick) begin
          req_d   = 1'b1;
          sel_d   = wave_sel_i;
          tmo_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // a response still completes when a tick collides with it
        if (tick) ov_set = 1'b1;
        if (sel_vld) begin
          data_d  = (sel_q == 2'd3) ? '0 : sel_smp;
          dvs_d   = 1'b1;
          state_d = IDLE;
          if (swp_act && swp_cnt_q != 8'hFF) swp_cnt_d = swp_cnt_q + 1'b1;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          to_set  = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    timeout_d = clear_flags_i ? 1'b0 : (timeout_q | to_set);
    overrun_d = clear_flags_i ? 1'b0 : (overrun_q | ov_set);
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      div_q     <= '0;
      sel_q     <= '0;
      tmo_q     <= '0;
      swp_cnt_q <= '0;
      phase_q   <= '0;
      data_q    <= '0;
      req_q     <= 1'b0;
      dvs_q     <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      sel_q     <= sel_d;
      tmo_q     <= tmo_d;
      swp_cnt_q <= swp_cnt_d;
      phase_q   <= phase_d;
      data_q    <= data_d;
      req_q     <= req_d;
      dvs_q     <= dvs_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  assign phase_o             = phase_q;
  assign next_data_strobe_o  = req_q;
  assign data_o              = data_q;
  assign data_valid_strobe_o = dvs_q;
  assign busy_o              = (state_q == WAIT);
  assign timeout_o           = timeout_q;
  assign overrun_o           = overrun_q;
endmodule
